// File: rtl/sys_pkg.sv
// Shared types and helpers for the systolic tile sequencer.
// Optional accumulate mode is enabled by defining SEQ_ACCUM_EN.
package sys_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_WRITEBACK,
    S_DONE
  } seq_state_t;

  localparam int ELEM_W = 16;
  typedef logic [ELEM_W-1:0] elem_t;

  // Cycles from the last feed until the far corner PE has its final sum.
  function automatic int drain_cycles(input int rows, input int cols, input int pe_lat);
    return 1 + (rows - 1) + (cols - 1) + pe_lat;
  endfunction

endpackage

// File: rtl/skew_buffer.sv
// Per-lane delay line: lane gi is delayed by gi cycles, lane 0 passes straight through.
// Data is forced to zero on lanes whose valid is low.
module skew_buffer #(
  parameter int LANES = 4,
  parameter int N     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LANES*N-1:0] in_data,
  input  logic               in_vld,
  output logic [LANES*N-1:0] out_data,
  output logic [LANES-1:0]   out_vld
);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    if (gi == 0) begin : g_pass
      assign out_vld[0]      = in_vld;
      assign out_data[0 +: N] = in_vld ? in_data[0 +: N] : '0;
    end else begin : g_delay
      logic [N-1:0]  data_reg [gi];
      logic [gi-1:0] vld_reg;

      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int j = 0; j < gi; j++) data_reg[j] <= '0;
          vld_reg <= '0;
        end else begin
          data_reg[0] <= in_data[gi*N +: N];
          vld_reg[0]  <= in_vld;
          for (int j = 1; j < gi; j++) begin
            data_reg[j] <= data_reg[j-1];
            vld_reg[j]  <= vld_reg[j-1];
          end
        end
      end

      assign out_vld[gi]         = vld_reg[gi-1];
      assign out_data[gi*N +: N] = vld_reg[gi-1] ? data_reg[gi-1] : '0;
    end
  end

endmodule

// File: rtl/systolic_sequencer.sv
// Tile sequencer: clears the array, streams skewed A/B tiles from BRAM, drains, reads rows out.
// Define SEQ_ACCUM_EN to add the accum input that skips the clear and accumulates across tiles.
module systolic_sequencer
  import sys_pkg::*;
#(
  parameter int N      = 16,
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int K_MAX  = 16,
  parameter int ADDR_W = 8,
  parameter int PE_LAT = 1,
  localparam int KW    = $clog2(K_MAX + 1),
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef SEQ_ACCUM_EN
  input  logic              accum,
`endif
  input  logic [KW-1:0]     k_len,
  output logic              busy,
  output logic              done,
  output logic              a_rd_en,
  output logic              b_rd_en,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  input  logic [ROWS*N-1:0] a_rd_data,
  input  logic [COLS*N-1:0] b_rd_data,
  output logic [ROWS*N-1:0] a_feed,
  output logic [COLS*N-1:0] b_feed,
  output logic [ROWS-1:0]   a_feed_vld,
  output logic [COLS-1:0]   b_feed_vld,
  output logic              arr_clear,
  output logic [RW-1:0]     arr_rd_row,
  input  logic [COLS*N-1:0] arr_rd_data,
  output logic [COLS*N-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int D  = drain_cycles(ROWS, COLS, PE_LAT);
  localparam int DW = $clog2(D + 1);

  seq_state_t    state_reg, state_next;
  logic [KW-1:0] k_len_reg, k_len_next;
  logic [KW-1:0] k_reg, k_next;
  logic [DW-1:0] drain_reg, drain_next;
  logic [RW-1:0] row_reg, row_next;
  logic          rd_vld_reg;
  logic          accum_req;
  logic [KW-1:0] k_len_clamped;

`ifdef SEQ_ACCUM_EN
  assign accum_req = accum;
`else
  assign accum_req = 1'b0;
`endif

  assign k_len_clamped = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= S_IDLE;
      k_len_reg  <= '0;
      k_reg      <= '0;
      drain_reg  <= '0;
      row_reg    <= '0;
      rd_vld_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      k_len_reg  <= k_len_next;
      k_reg      <= k_next;
      drain_reg  <= drain_next;
      row_reg    <= row_next;
      rd_vld_reg <= a_rd_en;
    end
  end

  always_comb begin
    state_next = state_reg;
    k_len_next = k_len_reg;
    k_next     = k_reg;
    drain_next = drain_reg;
    row_next   = row_reg;
    busy       = 1'b0;
    done       = 1'b0;
    a_rd_en    = 1'b0;
    b_rd_en    = 1'b0;
    a_addr     = '0;
    b_addr     = '0;
    arr_clear  = 1'b0;
    arr_rd_row = '0;
    out_valid  = 1'b0;
    out_data   = '0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          k_len_next = k_len_clamped;
          k_next     = '0;
          drain_next = '0;
          row_next   = '0;
          if (accum_req) state_next = (k_len_clamped == '0) ? S_WRITEBACK : S_FEED;
          else           state_next = S_CLEAR;
        end
      end
      S_CLEAR: begin
        busy       = 1'b1;
        arr_clear  = 1'b1;
        state_next = (k_len_reg == '0) ? S_WRITEBACK : S_FEED;
      end
      S_FEED: begin
        busy    = 1'b1;
        a_rd_en = 1'b1;
        b_rd_en = 1'b1;
        a_addr  = ADDR_W'(k_reg);
        b_addr  = ADDR_W'(k_reg);
        if (k_reg == k_len_reg - KW'(1)) begin
          state_next = S_DRAIN;
          drain_next = '0;
        end else begin
          k_next = k_reg + KW'(1);
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (drain_reg == DW'(D - 1)) state_next = S_WRITEBACK;
        else                         drain_next = drain_reg + DW'(1);
      end
      S_WRITEBACK: begin
        busy       = 1'b1;
        out_valid  = 1'b1;
        arr_rd_row = row_reg;
        out_data   = arr_rd_data;
        if (out_ready) begin
          if (row_reg == RW'(ROWS - 1)) state_next = S_DONE;
          else                          row_next   = row_reg + RW'(1);
        end
      end
      S_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  skew_buffer #(.LANES(ROWS), .N(N)) u_skew_a (
    .clk      (clk),
    .rst      (rst),
    .in_data  (a_rd_data),
    .in_vld   (rd_vld_reg),
    .out_data (a_feed),
    .out_vld  (a_feed_vld)
  );

  skew_buffer #(.LANES(COLS), .N(N)) u_skew_b (
    .clk      (clk),
    .rst      (rst),
    .in_data  (b_rd_data),
    .in_vld   (rd_vld_reg),
    .out_data (b_feed),
    .out_vld  (b_feed_vld)
  );

endmodule

// File: tb/tb_systolic_sequencer.sv
// Bench for systolic_sequencer on a 2x2 array with a BRAM model and a behavioural array model.
// Define SEQ_ACCUM_EN to also exercise the accumulate mode.
module tb_systolic_sequencer;

  localparam int N      = 16;
  localparam int ROWS   = 2;
  localparam int COLS   = 2;
  localparam int K_MAX  = 16;
  localparam int ADDR_W = 8;
  localparam int PE_LAT = 1;
  localparam int KW     = 5;
  localparam int RW     = 1;

  logic              clk = 1'b0;
  logic              rst, start;
`ifdef SEQ_ACCUM_EN
  logic              accum;
`endif
  logic [KW-1:0]     k_len;
  logic              busy, done, a_rd_en, b_rd_en;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [ROWS*N-1:0] a_rd_data, a_feed;
  logic [COLS*N-1:0] b_rd_data, b_feed;
  logic [ROWS-1:0]   a_feed_vld;
  logic [COLS-1:0]   b_feed_vld;
  logic              arr_clear, out_valid, out_ready;
  logic [RW-1:0]     arr_rd_row;
  logic [COLS*N-1:0] arr_rd_data, out_data;

  always #5 clk = ~clk;

  systolic_sequencer #(
    .N(N), .ROWS(ROWS), .COLS(COLS), .K_MAX(K_MAX), .ADDR_W(ADDR_W), .PE_LAT(PE_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef SEQ_ACCUM_EN
    .accum(accum),
`endif
    .k_len(k_len), .busy(busy), .done(done),
    .a_rd_en(a_rd_en), .b_rd_en(b_rd_en), .a_addr(a_addr), .b_addr(b_addr),
    .a_rd_data(a_rd_data), .b_rd_data(b_rd_data),
    .a_feed(a_feed), .b_feed(b_feed), .a_feed_vld(a_feed_vld), .b_feed_vld(b_feed_vld),
    .arr_clear(arr_clear), .arr_rd_row(arr_rd_row), .arr_rd_data(arr_rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // BRAM model: registered read, one cycle latency
  logic [ROWS*N-1:0] a_mem [K_MAX];
  logic [COLS*N-1:0] b_mem [K_MAX];

  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= a_mem[a_addr[3:0]];
    if (b_rd_en) b_rd_data <= b_mem[b_addr[3:0]];
  end

  // Behavioural array: pairs the k-th valid element of each A lane with the k-th of each B lane
  logic [N-1:0] acc   [ROWS][COLS];
  logic [N-1:0] a_cap [ROWS][K_MAX];
  logic [N-1:0] b_cap [COLS][K_MAX];
  int ka [ROWS];
  int kb [COLS];
  int kd [ROWS][COLS];
  logic busy_q = 1'b0;

  always @(posedge clk) begin
    if (busy && !busy_q) begin
      for (int r = 0; r < ROWS; r++) ka[r] = 0;
      for (int c = 0; c < COLS; c++) kb[c] = 0;
      for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) kd[r][c] = 0;
    end
    if (arr_clear)
      for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) acc[r][c] = '0;
    for (int r = 0; r < ROWS; r++)
      if (a_feed_vld[r] && ka[r] < K_MAX) begin
        a_cap[r][ka[r]] = a_feed[r*N +: N];
        ka[r]++;
      end
    for (int c = 0; c < COLS; c++)
      if (b_feed_vld[c] && kb[c] < K_MAX) begin
        b_cap[c][kb[c]] = b_feed[c*N +: N];
        kb[c]++;
      end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        while (kd[r][c] < ka[r] && kd[r][c] < kb[c]) begin
          acc[r][c] = acc[r][c] + a_cap[r][kd[r][c]] * b_cap[c][kd[r][c]];
          kd[r][c]++;
        end
    busy_q = busy;
  end

  always_comb begin
    arr_rd_data = '0;
    for (int c = 0; c < COLS; c++) arr_rd_data[c*N +: N] = acc[arr_rd_row][c];
  end

  typedef struct {
    int kl;
    int stall;
    bit poke;
    bit spec;
    int fv;
    int dn;
  } vec_t;

  vec_t tbl [6];
  logic [N-1:0] gold [ROWS][COLS];
  logic [COLS*N-1:0] exp_q [$];

  task automatic fill(input bit spec);
    for (int k = 0; k < K_MAX; k++) begin
      for (int r = 0; r < ROWS; r++) a_mem[k][r*N +: N] = N'($urandom_range(0, 15));
      for (int c = 0; c < COLS; c++) b_mem[k][c*N +: N] = N'($urandom_range(0, 15));
    end
    if (spec) begin
      a_mem[0] = {16'd4, 16'd1};
      a_mem[1] = {16'd5, 16'd2};
      a_mem[2] = {16'd6, 16'd3};
      b_mem[0] = {16'd0, 16'd1};
      b_mem[1] = {16'd1, 16'd0};
      b_mem[2] = {16'd1, 16'd1};
    end
  endtask

  task automatic check_idle(input string name);
    chk({name, "_ctrl"}, 64'({busy, done, a_rd_en, b_rd_en, arr_clear, out_valid,
                              a_feed_vld, b_feed_vld, a_addr, b_addr, arr_rd_row}), 64'(0));
    chk({name, "_feed"}, 64'({a_feed, b_feed}), 64'(0));
    chk({name, "_out"}, 64'(out_data), 64'(0));
  endtask

  task automatic run_tile(input vec_t v, input bit acc_mode);
    int kk, off, fv, dn, feeds, stall_left, idx;
    logic [COLS*N-1:0] row_w, held, exp_row;
    logic held_ok, ev;
    logic [N-1:0] ed;
    kk  = (v.kl > K_MAX) ? K_MAX : v.kl;
    off = acc_mode ? 1 : 0;
    fill(v.spec);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        if (!acc_mode) gold[r][c] = '0;
        for (int k = 0; k < kk; k++)
          gold[r][c] = gold[r][c] + a_mem[k][r*N +: N] * b_mem[k][c*N +: N];
      end
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) row_w[c*N +: N] = gold[r][c];
      exp_q.push_back(row_w);
    end
    @(negedge clk);
    start = 1'b1;
    k_len = KW'(v.kl);
`ifdef SEQ_ACCUM_EN
    accum = acc_mode;
`endif
    fv = -1; dn = -1; feeds = 0; stall_left = v.stall; held_ok = 1'b0; held = '0;
    for (int i = 1; i <= 150 && dn < 0; i++) begin
      @(negedge clk);
      start = v.poke && (i == 3);
      k_len = (v.poke && i == 3) ? KW'(5) : '0;
      chk("busy", 64'(busy), 64'(1));
      chk("arr_clear", 64'(arr_clear), 64'(!acc_mode && i == 1));
      ev = (i >= 2 - off) && (i < 2 - off + kk);
      chk("a_rd_en", 64'(a_rd_en), 64'(ev));
      chk("b_rd_en", 64'(b_rd_en), 64'(ev));
      if (a_rd_en) begin
        feeds++;
        chk("a_addr", 64'(a_addr), 64'(i - 2 + off));
        chk("b_addr", 64'(b_addr), 64'(i - 2 + off));
      end
      for (int r = 0; r < ROWS; r++) begin
        idx = i - 3 + off - r;
        ev  = (idx >= 0) && (idx < kk);
        ed  = '0;
        if (ev) ed = a_mem[idx][r*N +: N];
        chk("a_feed_vld", 64'(a_feed_vld[r]), 64'(ev));
        chk("a_feed", 64'(a_feed[r*N +: N]), 64'(ed));
      end
      for (int c = 0; c < COLS; c++) begin
        idx = i - 3 + off - c;
        ev  = (idx >= 0) && (idx < kk);
        ed  = '0;
        if (ev) ed = b_mem[idx][c*N +: N];
        chk("b_feed_vld", 64'(b_feed_vld[c]), 64'(ev));
        chk("b_feed", 64'(b_feed[c*N +: N]), 64'(ed));
      end
      if (out_valid && fv < 0) fv = i;
      if (out_valid && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
        if (held_ok) begin
          chk("hold_data", 64'(out_data), 64'(held));
          chk("hold_row", 64'(arr_rd_row), 64'(0));
        end
        held    = out_data;
        held_ok = 1'b1;
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        $display("xfer row=%0d data=%h", arr_rd_row, out_data);
        if (exp_q.size() == 0) chk("sb_empty", 64'(1), 64'(0));
        else begin
          exp_row = exp_q.pop_front();
          chk("out_data", 64'(out_data), 64'(exp_row));
        end
      end
      if (done) dn = i;
    end
    chk("first_valid", 64'(fv), 64'(v.fv));
    chk("done_cycle", 64'(dn), 64'(v.dn));
    chk("feed_cycles", 64'(feeds), 64'(kk));
    chk("sb_left", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'(0));
    chk("busy_end", 64'(busy), 64'(0));
  endtask

  initial begin
    bit seen;
    vec_t v;
    tbl[0] = '{kl: 3,  stall: 0, poke: 1'b0, spec: 1'b1, fv: 9,  dn: 11};
    tbl[1] = '{kl: 3,  stall: 5, poke: 1'b0, spec: 1'b1, fv: 9,  dn: 16};
    tbl[2] = '{kl: 1,  stall: 0, poke: 1'b1, spec: 1'b0, fv: 7,  dn: 9};
    tbl[3] = '{kl: 20, stall: 0, poke: 1'b0, spec: 1'b0, fv: 22, dn: 24};
    tbl[4] = '{kl: 0,  stall: 0, poke: 1'b0, spec: 1'b0, fv: 2,  dn: 4};
    tbl[5] = '{kl: 16, stall: 2, poke: 1'b1, spec: 1'b0, fv: 22, dn: 26};

    rst = 1'b0; start = 1'b0; k_len = '0; out_ready = 1'b1;
`ifdef SEQ_ACCUM_EN
    accum = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b1;

    for (int t = 0; t < 6; t++) run_tile(tbl[t], 1'b0);

    // Reset pulse in the middle of DRAIN aborts the tile silently
    fill(1'b1);
    @(negedge clk);
    start = 1'b1;
    k_len = KW'(3);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      start = 1'b0;
      k_len = '0;
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_idle("mid_rst");
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk("no_done_after_rst", 64'(seen), 64'(0));
    run_tile(tbl[0], 1'b0);

`ifdef SEQ_ACCUM_EN
    v = '{kl: 2, stall: 0, poke: 1'b0, spec: 1'b0, fv: 8, dn: 10};
    run_tile(v, 1'b0);
    v = '{kl: 3, stall: 0, poke: 1'b0, spec: 1'b0, fv: 8, dn: 10};
    run_tile(v, 1'b1);
`else
    v = tbl[2];
    run_tile(v, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
